serial_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one serial-input state machine (a 4-bit-state Moore/Mealy exercise core with `x_in` and `state[3:0]`) among four requesters. It grants the core to one requester at a time for a fixed-length burst:

- clears the core at the start of the burst;
- steers the granted requester's serial bit onto the core input;
- captures the core's final 4-bit state as the burst result.

It sits between the requesting stimulus sources and the single shared core instance.

---
 rtl/serial_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_serial_rr_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rr_arbiter.sv
// Round-robin arbiter that lends one shared serial state-machine core to four
// requesters, one fixed-length burst at a time, and captures the core's final state.
//
// state | meaning
// IDLE  | no grant; picks the next requester after r_last
// CLEAR | one-cycle synchronous clear of the shared core
// RUN   | BURST_LEN cycles of steered serial bits into the core
// DONE  | core state is final; captured into result on exit
module serial_rr_arbiter #(
  parameter int BURST_LEN = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] req,
  input  logic [3:0] x_req,
  input  logic [3:0] dp_state,
  output logic [3:0] grant,
  output logic       busy,
  output logic       dp_clr,
  output logic       dp_en,
  output logic       dp_x,
  output logic [3:0] result,
  output logic [1:0] result_id,
  output logic       burst_done,
  output logic       burst_abort
);

  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [3:0]    r_grant;
  logic [1:0]    r_last;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_result;
  logic [1:0]    r_result_id;
  logic          r_done;
  logic          r_abort;

  logic [1:0]    w_sel;
  logic [1:0]    w_cand;
  logic          w_lost;

  // Scan from farthest to nearest so the nearest requester after r_last wins.
  always_comb begin
    w_sel  = r_last;
    w_cand = '0;
    for (int i = 4; i >= 1; i--) begin
      w_cand = r_last + 2'(i);
      if (req[w_cand]) w_sel = w_cand;
    end
  end

  // r_last already holds the granted index for the whole burst.
  assign w_lost = ~req[r_last];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_last      <= 2'd3;
      r_cnt       <= '0;
      r_result    <= '0;
      r_result_id <= '0;
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_grant <= 4'(1) << w_sel;
            r_last  <= w_sel;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (w_lost) begin
            r_grant <= '0;
            r_abort <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_lost) begin
            r_grant <= '0;
            r_abort <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_result    <= dp_state;
          r_result_id <= r_last;
          r_done      <= 1'b1;
          r_grant     <= '0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign busy        = (r_state != S_IDLE);
  assign dp_clr      = (r_state == S_CLEAR);
  assign dp_en       = (r_state == S_RUN);
  assign dp_x        = dp_en & x_req[r_last];
  assign result      = r_result;
  assign result_id   = r_result_id;
  assign burst_done  = r_done;
  assign burst_abort = r_abort;

endmodule

// File: tb/tb_serial_rr_arbiter.sv
// Bench for serial_rr_arbiter: directed stimulus, a small shared-core model, and a
// scoreboard of expected burst_done/burst_abort events popped by a separate monitor.
module tb_serial_rr_arbiter;

  logic       clk;
  logic       rstn;
  logic [3:0] req;
  logic [3:0] x_req;
  logic [3:0] dp_state;
  logic [3:0] grant;
  logic       busy, dp_clr, dp_en, dp_x;
  logic [3:0] result;
  logic [1:0] result_id;
  logic       burst_done, burst_abort;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       ab;
    logic [1:0] id;
    logic [3:0] res;
  } exp_t;
  exp_t sb[$];

  serial_rr_arbiter #(.BURST_LEN(8)) dut (
    .clk(clk), .rstn(rstn), .req(req), .x_req(x_req), .dp_state(dp_state),
    .grant(grant), .busy(busy), .dp_clr(dp_clr), .dp_en(dp_en), .dp_x(dp_x),
    .result(result), .result_id(result_id),
    .burst_done(burst_done), .burst_abort(burst_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared core: CRC-4 style shift, x^4+x+1
  function automatic logic [3:0] core_step(input logic [3:0] s, input logic x);
    return {s[2:0], x} ^ (s[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] ref_core(input logic [7:0] bits);
    logic [3:0] s;
    s = 4'h0;
    for (int j = 0; j < 8; j++) s = core_step(s, bits[j]);
    return s;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn)       dp_state <= 4'h0;
    else if (dp_clr) dp_state <= 4'h0;
    else if (dp_en)  dp_state <= core_step(dp_state, dp_x);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic ab, input logic [1:0] id, input logic [3:0] res);
    exp_t e;
    e.ab = ab; e.id = id; e.res = res;
    sb.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest expected event
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && (burst_done === 1'b1 || burst_abort === 1'b1)) begin
        chk("pulse_exclusive", {31'b0, burst_done & burst_abort}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected done=%0b abort=%0b required=no_pulse", burst_done, burst_abort);
        end else begin
          e = sb.pop_front();
          chk("sb_kind_abort", {31'b0, burst_abort}, {31'b0, e.ab});
          chk("sb_result_id", {30'b0, result_id}, {30'b0, e.id});
          chk("sb_result", {28'b0, result}, {28'b0, e.res});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq;
    logic [1:0] id;
    seq = 8'b0100_1101;

    // Reset with all requests high
    rstn = 1'b0; req = 4'hF; x_req = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", {28'b0, grant}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_dp_clr", {31'b0, dp_clr}, 32'd0);
    chk("rst_dp_en", {31'b0, dp_en}, 32'd0);
    chk("rst_dp_x", {31'b0, dp_x}, 32'd0);
    chk("rst_result", {28'b0, result}, 32'd0);
    chk("rst_result_id", {30'b0, result_id}, 32'd0);
    chk("rst_done", {31'b0, burst_done}, 32'd0);
    chk("rst_abort", {31'b0, burst_abort}, 32'd0);

    // Round robin with all requests held: grants at edges 0,11,22,33,44
    rstn = 1'b1; x_req = 4'b1010;
    for (int b = 0; b < 5; b++) begin
      id = 2'(b);
      tick();
      chk("rr_grant", {28'b0, grant}, {28'b0, 4'(1) << id});
      chk("rr_dp_clr", {31'b0, dp_clr}, 32'd1);
      push(1'b0, id, ref_core({8{x_req[id]}}));
      if (b == 4) req = 4'b0001;
      repeat (9) tick();
      chk("rr_done_grant_held", {28'b0, grant}, {28'b0, 4'(1) << id});
      chk("rr_done_dp_en", {31'b0, dp_en}, 32'd0);
      tick();
      chk("rr_idle_grant", {28'b0, grant}, 32'd0);
      chk("rr_idle_busy", {31'b0, busy}, 32'd0);
    end
    req = 4'b0000;

    // Single request on requester 2 with a known bit sequence
    tick();
    req = 4'b0100; x_req = 4'b0000;
    tick();
    chk("single_grant", {28'b0, grant}, 32'h4);
    chk("single_dp_clr", {31'b0, dp_clr}, 32'd1);
    chk("single_dp_en_clear", {31'b0, dp_en}, 32'd0);
    push(1'b0, 2'd2, 4'hC);
    for (int j = 0; j < 8; j++) begin
      tick();
      x_req = {1'b0, seq[j], 2'b00};
      #1;
      chk("single_dp_en", {31'b0, dp_en}, 32'd1);
      chk("single_dp_clr_off", {31'b0, dp_clr}, 32'd0);
      chk("single_dp_x", {31'b0, dp_x}, {31'b0, seq[j]});
    end
    tick();
    chk("single_done_dp_en", {31'b0, dp_en}, 32'd0);
    chk("single_done_busy", {31'b0, busy}, 32'd1);
    tick();
    chk("single_result", {28'b0, result}, 32'hC);
    chk("single_result_id", {30'b0, result_id}, 32'd2);
    chk("single_grant_off", {28'b0, grant}, 32'd0);
    req = 4'b0000; x_req = 4'b0000;

    // Abort: requester 1 drops before RUN edge 3
    tick();
    req = 4'b0010;
    tick();
    chk("abort_grant", {28'b0, grant}, 32'h2);
    push(1'b1, 2'd2, 4'hC);
    tick();
    tick();
    req = 4'b0000;
    tick();
    chk("abort_dp_en", {31'b0, dp_en}, 32'd0);
    chk("abort_grant_off", {28'b0, grant}, 32'd0);
    chk("abort_result_kept", {28'b0, result}, 32'hC);
    chk("abort_result_id_kept", {30'b0, result_id}, 32'd2);
    req = 4'b0101; x_req = 4'b0100;
    tick();
    chk("abort_next_grant", {28'b0, grant}, 32'h4);
    push(1'b0, 2'd2, ref_core(8'hFF));
    repeat (10) tick();
    req = 4'b0000; x_req = 4'b0000;

    // Async reset in the middle of RUN
    tick();
    req = 4'b1000; x_req = 4'b1000;
    tick();
    chk("mrst_grant", {28'b0, grant}, 32'h8);
    repeat (4) tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("mrst_grant_off", {28'b0, grant}, 32'd0);
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_dp_en", {31'b0, dp_en}, 32'd0);
    chk("mrst_dp_x", {31'b0, dp_x}, 32'd0);
    chk("mrst_result", {28'b0, result}, 32'd0);
    chk("mrst_result_id", {30'b0, result_id}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1; req = 4'b1001; x_req = 4'b0001;
    tick();
    chk("mrst_next_grant", {28'b0, grant}, 32'h1);
    push(1'b0, 2'd0, ref_core(8'hFF));
    repeat (10) tick();
    req = 4'b0000; x_req = 4'b0000;

    // One-cycle request pulse: granted, then aborted at the CLEAR edge
    tick();
    req = 4'b1000;
    tick();
    chk("short_grant", {28'b0, grant}, 32'h8);
    chk("short_dp_clr", {31'b0, dp_clr}, 32'd1);
    req = 4'b0000;
    push(1'b1, 2'd0, 4'hD);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("short_dp_en", {31'b0, dp_en}, 32'd0);
      chk("short_grant_off", {28'b0, grant}, 32'd0);
    end

    repeat (3) tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
